// File: rtl/servo_position_controller.sv
// Servo position controller: seeks a commanded angle over the shortest wrap path, brakes, settles, holds, faults on timeout.
// Latency: every output is registered and reflects the state entered on the same edge. Backpressure: cmd_ready is low in INIT and FAULT.
// Optional macro SERVO_SOFTSTART_EN slews motor_duty by at most 4 per cycle while seeking.
module servo_position_controller #(
   parameter int ANGLE_W     = 12,
   parameter int PWM_W       = 8,
   parameter int PERIOD      = 100,
   parameter int MIN_DUTY    = 10,
   parameter int MAX_DUTY    = 80,
   parameter int KP_SHIFT    = 2,
   parameter int DEADBAND    = 4,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1 << 20,
   parameter int ATU_RST_CYC = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ANGLE_W-1:0] cmd_target,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ANGLE_W-1:0] current_angle,
   input  logic               clear_fault,
   output logic [PWM_W-1:0]   motor_period,
   output logic [PWM_W-1:0]   motor_duty,
   output logic [1:0]         motor_ctrl,
   output logic               clockwise,
   output logic               atu_reset,
   output logic               atu_monitor,
   output logic [31:0]        status_reg
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int IW = $clog2(ATU_RST_CYC + 1);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_SEEK   = 3'd2,
      S_SETTLE = 3'd3,
      S_HOLD   = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t             state, nstate;
   logic [ANGLE_W-1:0] target, target_n, err, mag, raw;
   logic [TW-1:0]      tcnt, tcnt_n;
   logic [SW-1:0]      scnt, scnt_n;
   logic [IW-1:0]      icnt, icnt_n;
   logic [PWM_W-1:0]   duty_clamp, duty_seek;
   logic [1:0]         ctrl_n;
   logic [31:0]        status_n;
   logic               acc, neg, in_band, cw_n;

   assign acc      = cmd_valid & cmd_ready;
   assign target_n = acc ? cmd_target : target;
   assign err      = target_n - current_angle;
   // The half-revolution error has no negative twin, so it is driven forward.
   assign neg      = err[ANGLE_W-1] && (err[ANGLE_W-2:0] != '0);
   assign mag      = neg ? -err : err;
   assign in_band  = mag <= ANGLE_W'(DEADBAND);
   assign raw      = mag >> KP_SHIFT;

   always_comb begin
      duty_clamp = PWM_W'(raw);
      if (raw < ANGLE_W'(MIN_DUTY))
         duty_clamp = PWM_W'(MIN_DUTY);
      else if (raw > ANGLE_W'(MAX_DUTY))
         duty_clamp = PWM_W'(MAX_DUTY);
   end

   always_comb begin
      nstate = state;
      tcnt_n = tcnt;
      scnt_n = scnt;
      icnt_n = icnt;
      if (acc) begin
         nstate = S_SEEK;
         tcnt_n = '0;
         scnt_n = '0;
      end else begin
         case (state)
            S_INIT: begin
               if (icnt == IW'(ATU_RST_CYC - 1))
                  nstate = S_IDLE;
               else
                  icnt_n = icnt + IW'(1);
            end
            S_SEEK: begin
               if (in_band) begin
                  nstate = S_SETTLE;
                  scnt_n = '0;
               end else begin
                  tcnt_n = (tcnt == TW'(TIMEOUT_CYC)) ? tcnt : tcnt + TW'(1);
                  if (tcnt >= TW'(TIMEOUT_CYC - 1))
                     nstate = S_FAULT;
               end
            end
            S_SETTLE: begin
               if (!in_band) begin
                  nstate = S_SEEK;
                  scnt_n = '0;
               end else begin
                  scnt_n = scnt + SW'(1);
                  if (scnt == SW'(SETTLE_CYC - 1))
                     nstate = S_HOLD;
               end
            end
            S_HOLD: begin
               if (!in_band) begin
                  nstate = S_SEEK;
                  tcnt_n = '0;
                  scnt_n = '0;
               end
            end
            S_FAULT: begin
               if (clear_fault)
                  nstate = S_IDLE;
            end
            S_IDLE:  nstate = S_IDLE;
            default: nstate = S_INIT;
         endcase
      end
   end

`ifdef SERVO_SOFTSTART_EN
   logic             seek_entry;
   logic [PWM_W-1:0] duty_base;
   assign seek_entry = (nstate == S_SEEK) && ((state != S_SEEK) || acc);
   assign duty_base  = seek_entry ? '0 : motor_duty;
   always_comb begin
      duty_seek = duty_clamp;
      if (duty_clamp > duty_base) begin
         if (duty_clamp - duty_base > PWM_W'(4))
            duty_seek = duty_base + PWM_W'(4);
      end else if (duty_base - duty_clamp > PWM_W'(4)) begin
         duty_seek = duty_base - PWM_W'(4);
      end
   end
`else
   assign duty_seek = duty_clamp;
`endif

   always_comb begin
      ctrl_n = 2'b00;
      cw_n   = 1'b0;
      if (nstate == S_SEEK) begin
         ctrl_n = neg ? 2'b10 : 2'b01;
         cw_n   = !neg;
      end else if (nstate == S_SETTLE || nstate == S_HOLD) begin
         ctrl_n = 2'b11;
      end
      status_n                = '0;
      status_n[ANGLE_W-1:0]   = current_angle;
      status_n[18:16]         = nstate;
      status_n[20]            = (nstate == S_SEEK) || (nstate == S_SETTLE);
      status_n[21]            = (nstate == S_HOLD);
      status_n[22]            = (nstate == S_FAULT);
      status_n[23]            = cw_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_INIT;
         target       <= '0;
         tcnt         <= '0;
         scnt         <= '0;
         icnt         <= '0;
         motor_period <= '0;
         motor_duty   <= '0;
         motor_ctrl   <= 2'b00;
         clockwise    <= 1'b0;
         atu_reset    <= 1'b1;
         atu_monitor  <= 1'b0;
         cmd_ready    <= 1'b0;
         status_reg   <= '0;
      end else begin
         state        <= nstate;
         target       <= target_n;
         tcnt         <= tcnt_n;
         scnt         <= scnt_n;
         icnt         <= icnt_n;
         motor_period <= PWM_W'(PERIOD);
         motor_duty   <= (nstate == S_SEEK) ? duty_seek : '0;
         motor_ctrl   <= ctrl_n;
         clockwise    <= cw_n;
         atu_reset    <= (nstate == S_INIT);
         atu_monitor  <= (nstate == S_SEEK) || (nstate == S_SETTLE) || (nstate == S_HOLD);
         cmd_ready    <= (nstate == S_IDLE) || (nstate == S_SEEK) ||
                         (nstate == S_SETTLE) || (nstate == S_HOLD);
         status_reg   <= status_n;
      end
   end
endmodule

// File: tb/tb_servo_position_controller.sv
// Bench for servo_position_controller: a cycle reference model queues expected outputs per edge,
// a monitor pops and compares them; a simple plant moves current_angle from the motor outputs.
module tb_servo_position_controller;
   localparam int AW = 12, PW = 8, REV = 4096, HALF = 2048;
   localparam int DB = 4, SETTLE = 16, TO = 64, ATU = 4, MIN_D = 10, MAX_D = 80, PER = 100;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] cmd_target = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] current_angle = 12'd100;
   logic          clear_fault = 1'b0;
   logic [PW-1:0] motor_period, motor_duty;
   logic [1:0]    motor_ctrl;
   logic          clockwise, atu_reset, atu_monitor;
   logic [31:0]   status_reg;

   servo_position_controller #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .cmd_target(cmd_target), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .current_angle(current_angle), .clear_fault(clear_fault),
      .motor_period(motor_period), .motor_duty(motor_duty), .motor_ctrl(motor_ctrl),
      .clockwise(clockwise), .atu_reset(atu_reset), .atu_monitor(atu_monitor),
      .status_reg(status_reg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  period;
      logic [7:0]  duty;
      logic [1:0]  ctrl;
      logic        cw;
      logic        ares;
      logic        mon;
      logic        rdy;
      logic [31:0] status;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   plant_en = 0;

   // Reference model state: mode uses the status-field codes (0 INIT .. 5 FAULT).
   int m_mode = 0, m_tgt = 0, m_init_cycles = 0, m_seek_cycles = 0, m_settle_cycles = 0, m_duty = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int shortest_err(input int tgt, input int cur);
      int e;
      e = ((tgt - cur) % REV + REV) % REV;
      return (e > HALF) ? e - REV : e;
   endfunction

   task automatic model_step();
      exp_t x;
      int   e, mag, want, base;
      bit   acc, far, entry;
      x = '0;
      if (reset) begin
         m_mode = 0; m_tgt = 0; m_init_cycles = 0; m_seek_cycles = 0; m_settle_cycles = 0; m_duty = 0;
         x.ares = 1'b1;
         q.push_back(x);
         return;
      end
      acc = cmd_valid && (m_mode >= 1 && m_mode <= 4);
      if (acc) m_tgt = int'(cmd_target);
      e     = shortest_err(m_tgt, int'(current_angle));
      mag   = (e < 0) ? -e : e;
      far   = mag > DB;
      entry = 0;
      if (acc) begin
         m_mode = 2; m_seek_cycles = 0; m_settle_cycles = 0; entry = 1;
      end else begin
         case (m_mode)
            0: begin
               m_init_cycles++;
               if (m_init_cycles == ATU) m_mode = 1;
            end
            2: if (!far) begin
                  m_mode = 3; m_settle_cycles = 0;
               end else begin
                  if (m_seek_cycles < TO) m_seek_cycles++;
                  if (m_seek_cycles == TO) m_mode = 5;
               end
            3: if (far) begin
                  m_mode = 2; m_settle_cycles = 0; entry = 1;
               end else begin
                  m_settle_cycles++;
                  if (m_settle_cycles == SETTLE) m_mode = 4;
               end
            4: if (far) begin
                  m_mode = 2; m_seek_cycles = 0; m_settle_cycles = 0; entry = 1;
               end
            5: if (clear_fault) m_mode = 1;
            default: ;
         endcase
      end
      want = mag / 4;
      if (want < MIN_D) want = MIN_D;
      if (want > MAX_D) want = MAX_D;
      if (m_mode == 2) begin
`ifdef SERVO_SOFTSTART_EN
         base   = entry ? 0 : m_duty;
         m_duty = (want > base) ? ((want - base > 4) ? base + 4 : want)
                                : ((base - want > 4) ? base - 4 : want);
`else
         base   = 0;
         m_duty = want + base;
`endif
      end else begin
         m_duty = 0;
      end
      x.period = 8'(PER);
      x.duty   = 8'(m_duty);
      x.ctrl   = (m_mode == 2) ? ((e < 0) ? 2'b10 : 2'b01) : ((m_mode == 3 || m_mode == 4) ? 2'b11 : 2'b00);
      x.cw     = (m_mode == 2) && (e >= 0);
      x.ares   = (m_mode == 0);
      x.mon    = (m_mode >= 2 && m_mode <= 4);
      x.rdy    = (m_mode >= 1 && m_mode <= 4);
      x.status = int'(current_angle) + (m_mode << 16) + (int'(m_mode == 2 || m_mode == 3) << 20)
               + (int'(m_mode == 4) << 21) + (int'(m_mode == 5) << 22) + (int'(x.cw) << 23);
      q.push_back(x);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t x;
      @(negedge clk);
      if (q.size() > 0) begin
         x = q.pop_front();
         check("motor_period", 32'(motor_period), 32'(x.period));
         check("motor_duty",   32'(motor_duty),   32'(x.duty));
         check("motor_ctrl",   32'(motor_ctrl),   32'(x.ctrl));
         check("clockwise",    32'(clockwise),    32'(x.cw));
         check("atu_reset",    32'(atu_reset),    32'(x.ares));
         check("atu_monitor",  32'(atu_monitor),  32'(x.mon));
         check("cmd_ready",    32'(cmd_ready),    32'(x.rdy));
         check("status_reg",   status_reg,        x.status);
      end
   end

   task automatic tick();
      int step;
      @(posedge clk);
      #1;
      if (plant_en) begin
         step = int'(motor_duty) / 2;
         if (step < 1) step = 1;
         if (motor_ctrl == 2'b01)      current_angle = current_angle + AW'(step);
         else if (motor_ctrl == 2'b10) current_angle = current_angle - AW'(step);
      end
   endtask

   task automatic issue(input int tgt);
      cmd_target = AW'(tgt);
      cmd_valid  = 1'b1;
      tick();
      cmd_valid  = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      repeat (3) tick();
      check("reset_status", status_reg, 32'd0);
      check("reset_period", 32'(motor_period), 32'd0);
      reset = 1'b0;
      repeat (3) tick();
      check("init_atu_reset", 32'(atu_reset), 32'd1);
      tick();
      check("init_done_atu_reset", 32'(atu_reset), 32'd0);
      check("idle_ready", 32'(cmd_ready), 32'd1);
      check("idle_state", 32'(status_reg[18:16]), 32'd1);

      // Move 100 -> 500 with the plant closing the loop.
      plant_en = 1;
      issue(500);
      check("move_ctrl", 32'(motor_ctrl), 32'd1);
      check("move_duty", 32'(motor_duty), 32'd80);
      n = 0;
      while (!status_reg[21] && n < 500) begin tick(); n++; end
      check("move_hold_done", 32'(status_reg[21]), 32'd1);
      check("move_hold_brake", 32'(motor_ctrl), 32'd3);

      // Shortest path across the wrap in both directions.
      plant_en = 0;
      current_angle = 12'd4090;
      issue(6);
      check("wrap_cw", 32'(clockwise), 32'd1);
      check("wrap_duty_min", 32'(motor_duty), 32'd10);
      current_angle = 12'd6;
      issue(4090);
      check("wrap_ccw_ctrl", 32'(motor_ctrl), 32'd2);

      // Retarget part-way through settling, then freeze the angle until timeout.
      current_angle = 12'd4090;
      tick();
      check("settle_state", 32'(status_reg[18:16]), 32'd3);
      repeat (7) tick();
      current_angle = 12'd800;
      issue(1000);
      check("retarget_state", 32'(status_reg[18:16]), 32'd2);
      check("retarget_duty", 32'(motor_duty), 32'd50);
      n = 0;
      while (!status_reg[22] && n < 200) begin tick(); n++; end
      check("timeout_cycles", n, 32'd64);
      check("fault_ctrl", 32'(motor_ctrl), 32'd0);
      check("fault_ready", 32'(cmd_ready), 32'd0);
      issue(5);
      check("fault_ignores_cmd", 32'(status_reg[18:16]), 32'd5);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("clear_fault_idle", 32'(status_reg[18:16]), 32'd1);

      // Reset in the middle of a seek.
      current_angle = 12'd100;
      issue(2000);
      check("preabort_seek", 32'(status_reg[18:16]), 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_status", status_reg, 32'd0);
      repeat (6) tick();

      // Randomised traffic against the reference model.
      plant_en = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) plant_en = ($urandom_range(0, 4) != 0);
         cmd_valid   = ($urandom_range(0, 15) == 0);
         cmd_target  = ($urandom_range(0, 1) == 0) ? AW'($urandom) : current_angle + AW'($urandom_range(0, 20)) - AW'(10);
         clear_fault = ($urandom_range(0, 31) == 0);
         reset       = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 99) == 0) current_angle = AW'($urandom);
         tick();
      end
      reset = 1'b0; cmd_valid = 1'b0; clear_fault = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/servo_position_controller.md
SERVO_POSITION_CONTROLLER -- requirements
Module: servo_position_controller

Interface
REQ-001 Parameter ANGLE_W, default 12: angle width; one revolution is 2^ANGLE_W counts; legal range 8..16.
REQ-002 Parameter PWM_W, default 8: width of motor_period and motor_duty.
REQ-003 Parameter PERIOD, default 100: constant value driven on motor_period.
REQ-004 Parameter MIN_DUTY, default 10; MAX_DUTY, default 80: duty clamp limits while seeking.
REQ-005 Parameter KP_SHIFT, default 2: duty_raw = |err| >> KP_SHIFT.
REQ-006 Parameter DEADBAND, default 4: on-target tolerance in counts.
REQ-007 Parameter SETTLE_CYC, default 16; TIMEOUT_CYC, default 2^20; ATU_RST_CYC, default 4.
REQ-008 Ports: clk in 1, the single clock; reset in 1, synchronous active-high.
REQ-009 cmd_target in ANGLE_W, target angle; cmd_valid in 1; cmd_ready out 1.
REQ-010 current_angle in ANGLE_W, from angle tracking unit; clear_fault in 1.
REQ-011 motor_period out PWM_W; motor_duty out PWM_W; motor_ctrl out 2 (00 off, 01 clockwise, 10 counter-clockwise, 11 brake).
REQ-012 clockwise out 1; atu_reset out 1; atu_monitor out 1; status_reg out 32.

Function
REQ-013 States: INIT, IDLE, SEEK, SETTLE, HOLD, FAULT; all outputs registered, updated one clk after the state/inputs that produce them.
REQ-014 INIT: atu_reset=1 for ATU_RST_CYC cycles, then IDLE; cmd_ready=0.
REQ-015 Command accepted on a cycle where cmd_valid&cmd_ready; target latched that cycle; cmd_ready=1 in IDLE, SEEK, SETTLE, HOLD, 0 in INIT, FAULT.
REQ-016 Accept in IDLE/SEEK/SETTLE/HOLD -> SEEK next cycle; timeout counter and settle counter cleared (retarget mid-move restarts seek).
REQ-017 err = (target - current_angle) mod 2^ANGLE_W read as signed ANGLE_W value (shortest path across wrap); err = -2^(ANGLE_W-1) treated as positive.
REQ-018 SEEK: err>0 -> motor_ctrl=01, clockwise=1; err<0 -> motor_ctrl=10, clockwise=0; motor_duty = clamp(|err|>>KP_SHIFT, MIN_DUTY, MAX_DUTY).
REQ-019 SEEK -> SETTLE when |err| <= DEADBAND; SEEK -> FAULT when timeout counter reaches TIMEOUT_CYC.
REQ-020 SETTLE: motor_ctrl=11, motor_duty=0; counts consecutive in-band cycles; |err| > DEADBAND -> SEEK (settle count cleared, timeout not cleared); count reaches SETTLE_CYC -> HOLD.
REQ-021 HOLD: motor_ctrl=11, motor_duty=0, done=1; drift beyond DEADBAND -> SEEK with timeout cleared.
REQ-022 IDLE and FAULT: motor_ctrl=00, motor_duty=0; FAULT exits to IDLE only on clear_fault; cmd_valid ignored in FAULT.
REQ-023 atu_monitor=1 in SEEK, SETTLE, HOLD; 0 otherwise; motor_period=PERIOD always except reset cycle.
REQ-024 status_reg: [ANGLE_W-1:0]=current_angle, upper angle bits 0, [18:16]=state code (INIT 0, IDLE 1, SEEK 2, SETTLE 3, HOLD 4, FAULT 5), [20] busy (SEEK|SETTLE), [21] done, [22] fault, [23] clockwise, others 0.
REQ-025 Timeout counter saturates; never wraps.

Reset
REQ-026 reset sampled on clk rising edge; overrides any simultaneous command or clear_fault.
REQ-027 During and on the cycle after reset: state=INIT, motor_ctrl=00, motor_duty=0, motor_period=0, clockwise=0, atu_reset=1, atu_monitor=0, cmd_ready=0, status_reg=0 except state field 0, latched target=0.
REQ-028 reset mid-SEEK aborts the move; latched target discarded.

Configuration
REQ-029 Macro SERVO_SOFTSTART_EN defined: in SEEK, motor_duty changes by at most 4 per cycle toward the clamped value, starting from 0 on SEEK entry from any state.
REQ-030 Macro SERVO_SOFTSTART_EN undefined: motor_duty takes the clamped value on the first SEEK output cycle.

Verification
REQ-031 Reset 3 cycles -> atu_reset=1 for ATU_RST_CYC=4 cycles after release, then state IDLE, cmd_ready=1.
REQ-032 current=100, cmd_target=500 -> motor_ctrl=01, motor_duty=80 (400>>2=100 clamped); model moves angle; at |err|<=4 brake, HOLD after 16 cycles, status_reg[21]=1.
REQ-033 ANGLE_W=12, current=4090, target=6 -> err=+12, clockwise=1, motor_duty=10 (3 clamped up); current=6, target=4090 -> motor_ctrl=10.
REQ-034 In SETTLE at 8 cycles, new cmd_target=1000 -> SEEK next cycle, settle count restarts, timeout restarts.
REQ-035 Angle frozen with err=200, TIMEOUT_CYC=64 -> FAULT after 64 SEEK cycles, motor_ctrl=00, cmd_ready=0; clear_fault -> IDLE.
REQ-036 SERVO_SOFTSTART_EN defined, err=400 -> motor_duty 4, 8, 12 ... reaching 80 after 20 cycles; undefined -> 80 immediately.
